// File: rtl/inv_key_schedule.sv
// inv_key_schedule: iterative AES-128/192/256 key expansion for decryption.
// Expands one 32-bit word per clock into a 60-word store, then serves the
// round keys from index Nr down to 0, one per accepted `next`.
// Optional build macro: KSCHED_ZEROIZE_EN clears the word store after the
// final key is consumed and on a restart issued while serving.
module inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key,
  input  logic [1:0]   switch,
  input  logic         start,
  input  logic         next,
  output logic [127:0] round_key,
  output logic         key_valid,
  output logic         last,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, SERVE = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [31:0] w_r [0:59];
  logic [5:0]  i_r;
  logic [2:0]  kcnt_r;          // i mod Nk, tracked incrementally
  logic [3:0]  nk_r, nr_r;
  logic [7:0]  rcon_r;
  logic [3:0]  ridx_r;

  logic        load_s, restart_s, expand_s, dec_s, done_s;
  logic [3:0]  nk_new_s, nr_new_s;
  logic [5:0]  last_i_s, base_s;
  logic [31:0] prev_s, back_s, t_s, new_word_s;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, b;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    b    = gf_mul(x252, x2);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  // Key-size decode of the live `switch` input, used only on a load edge.
  always_comb begin
    nk_new_s = 4'd8;
    nr_new_s = 4'd14;
    case (switch)
      2'b00:   begin nk_new_s = 4'd4; nr_new_s = 4'd10; end
      2'b01:   begin nk_new_s = 4'd6; nr_new_s = 4'd12; end
      default: begin nk_new_s = 4'd8; nr_new_s = 4'd14; end
    endcase
  end

  assign last_i_s = {nr_r, 2'b00} + 6'd3;

  // Next-state logic and one-hot-ish control strobes for the datapath.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    restart_s = 1'b0;
    expand_s  = 1'b0;
    dec_s     = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = EXPAND;
        end else begin
          state_s = IDLE;
        end
      end
      EXPAND: begin
        expand_s = 1'b1;
        if (i_r == last_i_s) state_s = SERVE;
        else                 state_s = EXPAND;
      end
      SERVE: begin
        if (start) begin
          load_s    = 1'b1;
          restart_s = 1'b1;
          state_s   = EXPAND;
        end else if (next) begin
          if (ridx_r == 4'd0) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            dec_s   = 1'b1;
            state_s = SERVE;
          end
        end else begin
          state_s = SERVE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // One expansion step: w[i] = w[i-Nk] ^ f(w[i-1]).
  always_comb begin
    prev_s = w_r[i_r - 6'd1];
    back_s = w_r[i_r - {2'b00, nk_r}];
    if (kcnt_r == 3'd0) begin
      t_s = sub_word({prev_s[23:0], prev_s[31:24]}) ^ {rcon_r, 24'h000000};
    end else if (nk_r == 4'd8 && kcnt_r == 3'd4) begin
      t_s = sub_word(prev_s);
    end else begin
      t_s = prev_s;
    end
    new_word_s = back_s ^ t_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Word store, expansion counters and serve index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 60; k++) w_r[k] <= 32'h0;
      i_r    <= 6'd0;
      kcnt_r <= 3'd0;
      nk_r   <= 4'd4;
      nr_r   <= 4'd10;
      rcon_r <= 8'h01;
      ridx_r <= 4'd0;
    end else if (load_s) begin
`ifdef KSCHED_ZEROIZE_EN
      if (restart_s) begin
        for (int k = 0; k < 60; k++) w_r[k] <= 32'h0;
      end
`endif
      for (int k = 0; k < 8; k++) begin
        if (k < int'(nk_new_s)) w_r[k] <= key[255 - 32*k -: 32];
      end
      nk_r   <= nk_new_s;
      nr_r   <= nr_new_s;
      i_r    <= {2'b00, nk_new_s};
      kcnt_r <= 3'd0;
      rcon_r <= 8'h01;
      ridx_r <= 4'd0;
    end else if (expand_s) begin
      w_r[i_r] <= new_word_s;
      i_r      <= i_r + 6'd1;
      if ({1'b0, kcnt_r} == nk_r - 4'd1) kcnt_r <= 3'd0;
      else                               kcnt_r <= kcnt_r + 3'd1;
      if (kcnt_r == 3'd0) rcon_r <= xtime(rcon_r);
      if (i_r == last_i_s) ridx_r <= nr_r;
    end else if (dec_s) begin
      ridx_r <= ridx_r - 4'd1;
    end else if (done_s) begin
`ifdef KSCHED_ZEROIZE_EN
      for (int k = 0; k < 60; k++) w_r[k] <= 32'h0;
`endif
      ridx_r <= 4'd0;
    end
  end

  assign base_s    = {ridx_r, 2'b00};
  assign key_valid = (state_r == SERVE);
  assign busy      = (state_r == EXPAND);
  assign last      = key_valid && (ridx_r == 4'd0);

  // Round-key output, held at zero whenever no key is being served.
  always_comb begin
    if (key_valid) begin
      round_key = {w_r[base_s], w_r[base_s + 6'd1], w_r[base_s + 6'd2], w_r[base_s + 6'd3]};
    end else begin
      round_key = 128'h0;
    end
  end

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

Iterative AES key expansion for the decryption datapath. Accepts a 128/192/256-bit cipher key and expands it into all round keys, one 32-bit word per clock. It then serves the round keys in reverse order (Nr down to 0), one per `next` request. It sits directly upstream of the decryption round stage and drives that stage's round-key input.

## Interface
Parameters:
- none. Sizes are fixed by AES: maximum 60 words.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key`  in  256  cipher key, left-aligned.
  - 128-bit key in `key[255:128]`; 192-bit key in `key[255:64]`; 256-bit key in `key[255:0]`.
  - Unused low bits are ignored.
- `switch`  in  2  key size: 00 = 128-bit (Nk=4, Nr=10); 01 = 192-bit (Nk=6, Nr=12); 10/11 = 256-bit (Nk=8, Nr=14).
- `start`  in  1  begins expansion; `key` and `switch` are sampled on the same edge.
- `next`  in  1  consumer has used the current `round_key`; advance to the next one.
- `round_key`  out  128  current round key, word 4r in bits [127:96]. Forced to 0 whenever `key_valid` = 0.
- `key_valid`  out  1  `round_key` holds key index r.
- `last`  out  1  `key_valid` and r = 0 (final AddRoundKey key).
- `busy`  out  1  expansion in progress.

## Operation
FSM states:
- IDLE: `busy` = 0, `key_valid` = 0. `start` → LOAD actions, then EXPAND.
- LOAD is folded into the `start` edge:
  - Words w[0..Nk-1] are written from `key`, MSB word first.
  - Nk/Nr are latched, i = Nk, rcon = 0x01, state → EXPAND.
- EXPAND: each cycle writes w[i] and increments i.
  - Let t = w[i-1].
  - If i mod Nk = 0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}; rcon = xtime(rcon), so 01,02,04,…,80,1B,36.
  - Else if Nk = 8 and i mod 8 = 4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
  - SubWord uses four instances of the codebase forward S-box.
  - When i = 4(Nr+1)-1 is written, ridx = Nr and state → SERVE.
- SERVE:
  - `key_valid` = 1; `round_key` = {w[4r], w[4r+1], w[4r+2], w[4r+3]} with r = ridx.
  - `next` with r > 0: ridx decrements.
  - `next` with r = 0: `key_valid` drops next cycle and state → IDLE.
- `start` in SERVE: abandons the remaining keys and restarts LOAD with new `key`/`switch`.
- `start` during EXPAND: ignored.
- `next` outside SERVE: ignored.
- `switch` changes after `start`: no effect until the next `start`.
- Reset, including mid-EXPAND or mid-SERVE:
  - state = IDLE; `busy`, `key_valid`, `last` = 0; `round_key` = 0.
  - ridx, i = 0; rcon = 0x01; all stored words = 0.

## Timing
- `start` sampled at edge E0; EXPAND occupies edges E1..E(4(Nr+1)-Nk).
- `key_valid` first goes high after edge 40 (AES-128), 46 (AES-192) or 52 (AES-256) following E0.
- `busy` is high from after E0 until the same edge at which `key_valid` rises.
- Serving rate: one key per cycle. With `next` held high, all Nr+1 keys appear on consecutive cycles.
- `round_key`, `key_valid` and `last` are combinational from registered state (ridx, state, words). There is no extra pipeline stage.
- `last` is high for exactly the cycle(s) where ridx = 0 in SERVE.

## Configuration
Macro: `KSCHED_ZEROIZE_EN`.
- Defined: word storage is cleared to 0 on the edge where the final `next` (r = 0) is accepted, and on a restart `start` in SERVE before the new key load. No key material remains after use.
- Not defined: storage is retained until overwritten by the next `start`. `round_key` output is still 0 while `key_valid` = 0.

## Test plan
- AES-128, key 000102030405060708090a0b0c0d0e0f, `switch` = 00:
  - `key_valid` rises 40 cycles after `start`.
  - First key = 13111d7fe3944a17f307a78b4d2b30c5.
  - Last key (`last` = 1) = 000102030405060708090a0b0c0d0e0f.
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c: first key = d014f9a8c9ee2589e13f0cc8b6630ca6; 11 keys served with `next` held high.
- AES-192, key 000102…1617, `switch` = 01:
  - Latency 46 cycles.
  - First key = a4970a331a78dc09c418c271e3a41d5d.
  - 13 keys served; `last` only on the 13th.
- AES-256, key 000102…1e1f, `switch` = 10:
  - Latency 52 cycles.
  - First key = 24fc79ccbf0979e9371ac23c6d68de36.
  - Last key = 000102…0e0f.
- `rst_n` low for 1 cycle at cycle 20 of an AES-128 expansion:
  - All outputs 0 immediately.
  - A second `start` yields correct keys with latency 40.
  - `start` pulses during EXPAND are ignored, and latency stays 40.
- In SERVE at r = 5, assert `start` with a new key: keys restart from the new key's index Nr after the full latency. With `KSCHED_ZEROIZE_EN`, internal storage reads 0 after the final `next`.
